pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Parametrised program-counter unit feeding instruction fetch.
- Replaces the fixed 32-bit free-running PC register and its +4 / jump adders with one sequencer. It adds:
  - a valid/ready fetch handshake and a stall input;
  - a prioritised redirect network: trap, trap-return, execute-stage redirect, return-address-stack pop;
  - a circular return address stack (RAS) and misaligned-target detection.
- Sits between the control/execute stages and the instruction memory port.

Parameters:
- XLEN, 32, address/PC width in bits (≥16).
- RESET_VEC, 0, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned redirect; truncated to XLEN.
- RAS_DEPTH, 4, number of RAS entries (power of 2, ≥2).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- fetch_valid  out  1  fetch_pc is valid for fetch
- fetch_ready  in  1  fetch port accepts fetch_pc this cycle
- fetch_pc  out  XLEN  current PC
- stall  in  1  hold PC; blocks sequential advance and RAS ops
- trap_valid  in  1  take exception
- trap_pc  in  XLEN  faulting PC, saved to epc
- mret_valid  in  1  return from trap
- redir_valid  in  1  execute-stage redirect (branch/jump)
- redir_base  in  XLEN  redirect base (PC or register)
- redir_offset  in  XLEN  redirect offset (sign-extended immediate)
- redir_clr_lsb  in  1  clear bit 0 of target (register-indirect jump)
- call_push  in  1  push ras_push_addr onto RAS
- ras_push_addr  in  XLEN  return address to push
- ret_pop  in  1  predicted return: pop RAS top into PC
- epc  out  XLEN  saved exception PC
- misalign_err  out  1  one-cycle pulse: redirect target misaligned
- ras_empty  out  1  RAS count == 0

Behaviour:
- Reset is asynchronous and active-high; clock is clk. While reset is high:
  - fetch_pc=RESET_VEC, fetch_valid=0, epc=0, misalign_err=0;
  - RAS pointer=0, count=0, ras_empty=1; RAS contents are don't-care.
- First rising edge with reset low: fetch_valid←1. fetch_valid then stays 1 until the next reset.
- fetch_pc is a register. Every update below takes effect at the next rising edge.
- Redirect target: tgt = (redir_base + redir_offset) mod 2^XLEN; then tgt[0]←0 if redir_clr_lsb. Target is misaligned if tgt[1:0]≠0 after clearing.
- Next-PC priority, highest first, one source per cycle. Trap, mret and redir apply regardless of stall/fetch_ready.
  1. trap_valid: PC←TRAP_VEC; epc←trap_pc.
  2. mret_valid: PC←epc (value before this edge).
  3. redir_valid & misaligned: PC←TRAP_VEC; epc←tgt; misalign_err=1 for exactly the following cycle.
  4. redir_valid aligned: PC←tgt.
  5. !stall & ret_pop & count>0: PC←RAS top.
  6. !stall & fetch_valid & fetch_ready: PC←PC+4, wrapping mod 2^XLEN.
  7. Otherwise PC holds.
- ret_pop with count==0: no pop; fall through to rule 6 (sequential). ras_empty stays 1.
- RAS ops are suppressed when trap_valid, mret_valid, redir_valid or stall is high. Otherwise:
  - push only: write entry[ptr], ptr←ptr+1 mod RAS_DEPTH, count←min(count+1, RAS_DEPTH). A push when full overwrites the oldest entry (circular).
  - pop only (count>0): ptr←ptr−1 mod RAS_DEPTH, count←count−1. Top = entry[ptr−1].
  - push and pop in the same cycle (count>0): PC←old top; the top entry is replaced by ras_push_addr; ptr and count unchanged.
  - push and pop in the same cycle (count==0): acts as a push only; PC follows rule 6.
- misalign_err is registered, deasserts after one cycle and is 0 on all other cycles.
- Reset mid-operation: all state returns to reset values immediately. There is no pending redirect memory.

Test Plan:
- Reset with RESET_VEC=0; release; fetch_ready=1 for 3 cycles → fetch_valid=1 one edge after release; fetch_pc sequence 0, 4, 8, 12.
- fetch_ready=0 for 2 cycles, then stall=1 with fetch_ready=1 → fetch_pc holds; advances by 4 only after stall drops.
- redir_valid with base=0x100, offset=0xFFFF_FFF8 (−8) → fetch_pc=0xF8. Then base=0x201, offset=0, clr_lsb=1 → 0x200. Then base=0x102, offset=0 → fetch_pc=TRAP_VEC, epc=0x102, misalign_err high exactly one cycle.
- Same cycle trap_valid (trap_pc=0x40), redir_valid and ret_pop → fetch_pc=0x100, epc=0x40, RAS unchanged. Next cycle mret_valid → fetch_pc=0x40.
- RAS_DEPTH=4: push 0x10, 0x20, 0x30, 0x40, 0x50, then 5 ret_pops → PCs 0x50, 0x40, 0x30, 0x20. The fifth pop finds RAS empty (ras_empty=1) and PC advances by 4.
- With 0x10 on RAS, push 0x80 and pop in the same cycle → PC=0x10. Next pop → PC=0x80, ras_empty=1. Async reset asserted mid-cycle → fetch_pc=RESET_VEC, fetch_valid=0 before the next edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit for instruction fetch.
// Selects the next PC from a prioritised set of sources (trap, trap-return,
// execute redirect, return-address-stack pop, sequential +4, hold). It also
// keeps the saved exception PC and a circular return address stack.
//
// Handshake: fetch_pc is offered while fetch_valid is high. It is consumed
// on a rising edge where fetch_valid && fetch_ready && !stall, and then
// advances by 4. While fetch_valid is low, or fetch_ready is low, or stall is
// high, the offered fetch_pc holds unless a redirect source overrides it.
module pc_sequencer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [31:0]     TRAP_VEC  = 32'h0000_0100,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret_valid,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_base,
  input  logic [XLEN-1:0] redir_offset,
  input  logic            redir_clr_lsb,
  input  logic            call_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ret_pop,
  output logic [XLEN-1:0] epc,
  output logic            misalign_err,
  output logic            ras_empty
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] TRAP_VEC_X = XLEN'(TRAP_VEC);
  localparam logic [CW-1:0]   RAS_FULL   = CW'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr;
  logic [CW-1:0]   ras_cnt;

  logic [XLEN-1:0] tgt_sum;
  logic [XLEN-1:0] tgt;
  logic            tgt_misaligned;
  logic            ras_en;
  logic            ras_nonempty;
  logic            do_push;
  logic            do_pop;
  logic [PW-1:0]   ptr_top;
  logic [XLEN-1:0] ras_top;

  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] epc_next;
  logic            misal_next;

  // Redirect target computation and RAS operation decode.
  always_comb begin
    tgt_sum        = redir_base + redir_offset;
    tgt            = {tgt_sum[XLEN-1:1], tgt_sum[0] & ~redir_clr_lsb};
    tgt_misaligned = (tgt[1:0] != 2'b00);
    ras_en         = !(trap_valid || mret_valid || redir_valid || stall);
    ras_nonempty   = (ras_cnt != '0);
    do_push        = ras_en && call_push;
    do_pop         = ras_en && ret_pop && ras_nonempty;
    ptr_top        = ras_ptr - PW'(1);
    ras_top        = ras_mem[ptr_top];
  end

  // Next-PC priority network; one source wins each cycle.
  always_comb begin
    pc_next    = fetch_pc;
    epc_next   = epc;
    misal_next = 1'b0;
    if (trap_valid) begin
      pc_next  = TRAP_VEC_X;
      epc_next = trap_pc;
    end else if (mret_valid) begin
      pc_next = epc;
    end else if (redir_valid && tgt_misaligned) begin
      pc_next    = TRAP_VEC_X;
      epc_next   = tgt;
      misal_next = 1'b1;
    end else if (redir_valid) begin
      pc_next = tgt;
    end else if (do_pop) begin
      pc_next = ras_top;
    end else if (!stall && fetch_valid && fetch_ready) begin
      pc_next = fetch_pc + XLEN'(4);
    end
  end

  // PC, exception PC, error pulse and fetch-valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc     <= RESET_VEC;
      fetch_valid  <= 1'b0;
      epc          <= '0;
      misalign_err <= 1'b0;
    end else begin
      fetch_pc     <= pc_next;
      fetch_valid  <= 1'b1;
      epc          <= epc_next;
      misalign_err <= misal_next;
    end
  end

  // RAS pointer and occupancy; push+pop together leaves both unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (do_push && !do_pop) begin
      ras_ptr <= ras_ptr + PW'(1);
      if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + CW'(1);
    end else if (do_pop && !do_push) begin
      ras_ptr <= ptr_top;
      ras_cnt <= ras_cnt - CW'(1);
    end
  end

  // RAS storage; a combined push+pop replaces the top entry in place.
  always_ff @(posedge clk) begin
    if (do_push && do_pop) ras_mem[ptr_top] <= ras_push_addr;
    else if (do_push)      ras_mem[ras_ptr] <= ras_push_addr;
  end

  assign ras_empty = !ras_nonempty;

endmodule
